// File: rtl/combat_pkg.sv
// Shared types and constants for the combat arbiter.
// Round states, winner codes, box field offsets and counter widths.
package combat_pkg;

    typedef enum logic [1:0] {
        RS_IDLE    = 2'd0,
        RS_FIGHT   = 2'd1,
        RS_HITSTOP = 2'd2,
        RS_OVER    = 2'd3
    } round_state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam int BOX_W   = 40;
    localparam int COORD_W = 10;
    localparam int X1_HI = 39, X1_LO = 30;
    localparam int X2_HI = 29, X2_LO = 20;
    localparam int Y1_HI = 19, Y1_LO = 10;
    localparam int Y2_HI = 9,  Y2_LO = 0;

    localparam int HEALTH_W = 3;
    localparam int STUN_W   = 4;
    localparam int STOP_W   = 4;
    localparam int SECS_W   = 7;

    function automatic logic [1:0] ko_winner(
        input logic [HEALTH_W-1:0] h1,
        input logic [HEALTH_W-1:0] h2
    );
        if (h1 == '0 && h2 == '0) return WIN_DRAW;
        if (h2 == '0)             return WIN_P1;
        return WIN_P2;
    endfunction

    function automatic logic [1:0] timeout_winner(
        input logic [HEALTH_W-1:0] h1,
        input logic [HEALTH_W-1:0] h2
    );
        if (h1 > h2) return WIN_P1;
        if (h2 > h1) return WIN_P2;
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Inclusive axis-aligned overlap test of two packed {x1,x2,y1,y2} boxes.
module box_overlap
    import combat_pkg::*;
(
    input  logic [BOX_W-1:0] a,
    input  logic [BOX_W-1:0] b,
    output logic             hit
);

    logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
    logic [COORD_W-1:0] bx1, bx2, by1, by2;

    assign ax1 = a[X1_HI:X1_LO];
    assign ax2 = a[X2_HI:X2_LO];
    assign ay1 = a[Y1_HI:Y1_LO];
    assign ay2 = a[Y2_HI:Y2_LO];
    assign bx1 = b[X1_HI:X1_LO];
    assign bx2 = b[X2_HI:X2_LO];
    assign by1 = b[Y1_HI:Y1_LO];
    assign by2 = b[Y2_HI:Y2_LO];

    assign hit = (ax1 <= bx2) && (bx1 <= ax2) &&
                 (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/combat_arbiter.sv
// Per-frame hit resolution, health/hitstun and round FSM for two players.
// Round timer is built only when COMBAT_ARBITER_TIMER_EN is defined.
module combat_arbiter
    import combat_pkg::*;
#(
    parameter int HEALTH_INIT    = 3,
    parameter int HITSTUN_FRAMES = 8,
    parameter int HITSTOP_FRAMES = 4,
    parameter int FRAMES_PER_SEC = 60,
    parameter int ROUND_SECS     = 99
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                start,
    input  logic [BOX_W-1:0]    p1_hitbox,
    input  logic [BOX_W-1:0]    p2_hitbox,
    input  logic                p1_hit_active,
    input  logic                p2_hit_active,
    input  logic [BOX_W-1:0]    p1_hurtbox,
    input  logic [BOX_W-1:0]    p2_hurtbox,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_stun,
    output logic                p2_stun,
    output logic                freeze,
    output logic [1:0]          round_state,
    output logic [SECS_W-1:0]   timer_secs,
    output logic [1:0]          winner
);

    localparam logic [HEALTH_W-1:0] H_INIT = HEALTH_W'(HEALTH_INIT);
    localparam logic [STUN_W-1:0]   STUN_LD = STUN_W'(HITSTUN_FRAMES);
    localparam logic [STOP_W-1:0]   STOP_LD = STOP_W'(HITSTOP_FRAMES);

    round_state_t        st, st_n;
    logic [HEALTH_W-1:0] h1, h1_n, h2, h2_n;
    logic [STUN_W-1:0]   s1, s1_n, s2, s2_n;
    logic [STOP_W-1:0]   hs, hs_n;
    logic [1:0]          win, win_n;
    logic                l1, l1_n, l2, l2_n;
    logic                hit12, hit21, acc12, acc21;

    box_overlap u_ov12 (.a(p1_hitbox), .b(p2_hurtbox), .hit(hit12));
    box_overlap u_ov21 (.a(p2_hitbox), .b(p1_hurtbox), .hit(hit21));

    assign acc12 = p1_hit_active && hit12 && !l1;
    assign acc21 = p2_hit_active && hit21 && !l2;

`ifdef COMBAT_ARBITER_TIMER_EN
    localparam int SUB_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [SUB_W-1:0]  SUB_TOP = SUB_W'(FRAMES_PER_SEC - 1);
    localparam logic [SECS_W-1:0] SECS_INIT = SECS_W'(ROUND_SECS);

    logic [SUB_W-1:0]  sub, sub_n;
    logic [SECS_W-1:0] secs, secs_n;

    assign timer_secs = secs;
`else
    // Timer hardware absent; FRAMES_PER_SEC only qualifies the constant.
    assign timer_secs = (FRAMES_PER_SEC > 0) ? SECS_W'(ROUND_SECS) : '0;
`endif

    always_comb begin
        st_n  = st;
        h1_n  = h1;
        h2_n  = h2;
        s1_n  = s1;
        s2_n  = s2;
        hs_n  = hs;
        win_n = win;
        l1_n  = l1;
        l2_n  = l2;
`ifdef COMBAT_ARBITER_TIMER_EN
        sub_n  = sub;
        secs_n = secs;
`endif
        if (frame_tick) begin
            if (!p1_hit_active) l1_n = 1'b0;
            if (!p2_hit_active) l2_n = 1'b0;
            unique case (st)
                RS_IDLE, RS_OVER: begin
                    if (start) begin
                        st_n  = RS_FIGHT;
                        h1_n  = H_INIT;
                        h2_n  = H_INIT;
                        s1_n  = '0;
                        s2_n  = '0;
                        win_n = WIN_NONE;
`ifdef COMBAT_ARBITER_TIMER_EN
                        sub_n  = '0;
                        secs_n = SECS_INIT;
`endif
                    end
                end
                RS_FIGHT: begin
                    if (s1 != '0) s1_n = s1 - 1'b1;
                    if (s2 != '0) s2_n = s2 - 1'b1;
                    if (acc12) begin
                        if (h2 != '0) h2_n = h2 - 1'b1;
                        s2_n = STUN_LD;
                        l1_n = 1'b1;
                    end
                    if (acc21) begin
                        if (h1 != '0) h1_n = h1 - 1'b1;
                        s1_n = STUN_LD;
                        l2_n = 1'b1;
                    end
                    if (acc12 || acc21) begin
                        hs_n = STOP_LD;
                        st_n = RS_HITSTOP;
                    end
`ifdef COMBAT_ARBITER_TIMER_EN
                    // A hit in the expiry tick suppresses the timer step.
                    else if (sub == SUB_TOP) begin
                        sub_n  = '0;
                        secs_n = secs - 1'b1;
                        if (secs == SECS_W'(1)) begin
                            st_n  = RS_OVER;
                            win_n = timeout_winner(h1, h2);
                            s1_n  = '0;
                            s2_n  = '0;
                        end
                    end else begin
                        sub_n = sub + 1'b1;
                    end
`endif
                end
                RS_HITSTOP: begin
                    hs_n = hs - 1'b1;
                    if (hs == STOP_W'(1)) begin
                        if (h1 == '0 || h2 == '0) begin
                            st_n  = RS_OVER;
                            win_n = ko_winner(h1, h2);
                            s1_n  = '0;
                            s2_n  = '0;
                        end else begin
                            st_n = RS_FIGHT;
                        end
                    end
                end
                default: st_n = RS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= RS_IDLE;
            h1  <= H_INIT;
            h2  <= H_INIT;
            s1  <= '0;
            s2  <= '0;
            hs  <= '0;
            win <= WIN_NONE;
            l1  <= 1'b0;
            l2  <= 1'b0;
`ifdef COMBAT_ARBITER_TIMER_EN
            sub  <= '0;
            secs <= SECS_INIT;
`endif
        end else begin
            st  <= st_n;
            h1  <= h1_n;
            h2  <= h2_n;
            s1  <= s1_n;
            s2  <= s2_n;
            hs  <= hs_n;
            win <= win_n;
            l1  <= l1_n;
            l2  <= l2_n;
`ifdef COMBAT_ARBITER_TIMER_EN
            sub  <= sub_n;
            secs <= secs_n;
`endif
        end
    end

    assign round_state = st;
    assign p1_health   = h1;
    assign p2_health   = h2;
    assign p1_stun     = (s1 != '0);
    assign p2_stun     = (s2 != '0);
    assign freeze      = (st == RS_HITSTOP);
    assign winner      = win;

endmodule

// File: doc/combat_arbiter.md
# combat_arbiter

Per-frame combat controller for the two-player fighting game. Each frame it takes both players' hitbox and hurtbox coordinates, resolves hits including simultaneous trades, and keeps health and hitstun for each player. It also runs the round state machine (idle, fight, hitstop, over) and the round timer. It sits between the two `player` instances and `color_decider`/HUD. It gates player motion through `p1_stun`, `p2_stun` and `freeze`.

## Interface
Reset is synchronous and active-high.

Parameters:
- `HEALTH_INIT`, 3: starting health per player, 1..7.
- `HITSTUN_FRAMES`, 8: frames a struck player is stunned, 1..15.
- `HITSTOP_FRAMES`, 4: frames the whole game freezes after an accepted hit, 1..15.
- `FRAMES_PER_SEC`, 60: `frame_tick` count per timer second.
- `ROUND_SECS`, 99: round length in seconds, 1..99.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-cycle strobe, once per video frame.
- `start` in 1: level; begins a round from IDLE or OVER.
- `p1_hitbox`, `p2_hitbox` in 40: {x1,x2,y1,y2}, 10 bits each, inclusive corners.
- `p1_hit_active`, `p2_hit_active` in 1: the hitbox is live; high only in the attack-end state.
- `p1_hurtbox`, `p2_hurtbox` in 40: {x1,x2,y1,y2}, same packing.
- `p1_health`, `p2_health` out 3: current health.
- `p1_stun`, `p2_stun` out 1: player input must be ignored while high.
- `freeze` out 1: high in HITSTOP; both players hold state.
- `round_state` out 2: 0 IDLE, 1 FIGHT, 2 HITSTOP, 3 OVER.
- `timer_secs` out 7: remaining seconds.
- `winner` out 2: 0 none, 1 P1, 2 P2, 3 draw.

## Operation
- Overlap test: A and B overlap iff `A.x1<=B.x2 && B.x1<=A.x2 && A.y1<=B.y2 && B.y1<=A.y2`. The test is unsigned, 10-bit, and touching edges count as overlap.
- `hit12` = `p1_hit_active` && overlap(`p1_hitbox`, `p2_hurtbox`). `hit21` is symmetric.
- Once-per-attack rule:
  - Flag `p1_landed` sets when a P1 hit is accepted.
  - It clears on any `frame_tick` where `p1_hit_active`=0.
  - `hit12` is ignored while `p1_landed`=1. P2 is symmetric.
- All evaluation happens only on cycles with `frame_tick`=1. Other cycles hold all state.
- IDLE:
  - Health = `HEALTH_INIT`, timer = `ROUND_SECS`, stun = 0, `winner`=0.
  - `start` -> FIGHT.
- FIGHT, per tick:
  1. Decrement nonzero stun counters.
  2. Resolve hits:
     - Accepted `hit12` only: P2 health −1, P2 stun loads `HITSTUN_FRAMES`.
     - Both accepted in the same tick: a trade. Both health −1 and both stuns load.
     - Health saturates at 0.
  3. Any accepted hit: load the hitstop counter with `HITSTOP_FRAMES` and go to HITSTOP.
  4. Otherwise advance the frame sub-counter. On wrap at `FRAMES_PER_SEC`−1, decrement `timer_secs`. When `timer_secs` reaches 0, go to OVER.
- HITSTOP:
  - Stun, timer and the sub-counter are frozen; only the hitstop counter decrements.
  - At 0: if either health is 0, go to OVER; else go to FIGHT.
- Entry to OVER sets `winner`:
  - One health 0: the other player wins.
  - Both 0: draw.
  - Timeout: higher health wins; equal health is a draw.
  - Stun is cleared.
- OVER: `start` (sampled on a tick) reinitialises as IDLE does and enters FIGHT directly.
- `start` is ignored in FIGHT and HITSTOP.

## Timing
- Reset value of every output: `round_state`=IDLE, both health=`HEALTH_INIT`, stun=0, `freeze`=0, `timer_secs`=`ROUND_SECS`, `winner`=0.
- All outputs are registered. Effects of a tick are visible the cycle after the `frame_tick` edge.
- Inputs are sampled only in the `frame_tick` cycle and need not be stable elsewhere.
- `rst` mid-round overrides everything in the same edge, including an in-flight hitstop.
- A hit that lands in the same tick the timer would expire: the hit wins, and the state goes to HITSTOP, not OVER.
- Stun reloads to `HITSTUN_FRAMES` if the player is hit while already stunned; it does not accumulate.

## Configuration
- `COMBAT_ARBITER_TIMER_EN` defined: the round timer operates as described.
- Undefined:
  - No sub-counter or seconds counter is built.
  - `timer_secs` is constant `ROUND_SECS`.
  - A round ends only by KO.

## Structure
- Package `combat_pkg` holds:
  - the `round_state` enum;
  - the `winner` encodings;
  - box field bit offsets (X1=39:30, X2=29:20, Y1=19:10, Y2=9:0);
  - the health and counter widths.
- Sub-module `box_overlap`: combinational 40-bit × 40-bit overlap test, instanced twice.

## Test plan
- Reset, then `start`, then one tick with P1 box {100,150,50,100} active vs P2 hurt {150,200,0,200} (edge touch):
  - P2 health 3->2, `p2_stun`=1, `round_state`=HITSTOP;
  - 4 ticks later, FIGHT.
- P1 holds `hit_active` over 10 overlapping ticks: exactly one decrement. Drop `hit_active` for one tick, reassert: a second decrement.
- Simultaneous `hit12` and `hit21` at health 1/1: both reach 0, then HITSTOP, then OVER with `winner`=3.
- No hits, `ROUND_SECS`=2, `FRAMES_PER_SEC`=3: OVER after 6 ticks, `winner`=3. Repeat with P1 health ahead: `winner`=1.
- Assert `rst` during HITSTOP: the next cycle, all outputs are at their reset values.
- Macro undefined: 10000 ticks without hits leave the round in FIGHT with `timer_secs`=`ROUND_SECS`.
